// File: rtl/xfer_scheduler_pkg.sv
// Shared types for the SD transfer scheduler: FSM state encoding and latched Transfer Mode fields.
package xfer_scheduler_pkg;

  typedef enum logic [2:0] {
    XsIdle     = 3'd0,
    XsCmdIssue = 3'd1,
    XsCmdWait  = 3'd2,
    XsDatIssue = 3'd3,
    XsDatXfer  = 3'd4,
    XsGap      = 3'd5,
    XsDone     = 3'd6
  } xs_state_e;

  typedef struct packed {
    logic multi;
    logic read;
    logic bcnt_en;
    logic dma_en;
  } xfer_mode_t;

endpackage

// File: rtl/blk_counter.sv
// Remaining-block counter; saturates at zero and is pinned to zero in unbounded mode.
module blk_counter #(
  parameter int unsigned BLK_W = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             load,
  input  logic [BLK_W-1:0] load_value,
  input  logic             unbounded,
  input  logic             dec,
  output logic [BLK_W-1:0] count,
  output logic             zero
);

  logic [BLK_W-1:0] count_q, count_d;
  logic             unbounded_q, unbounded_d;

  always_comb begin
    count_d     = count_q;
    unbounded_d = unbounded_q;
    if (load) begin
      unbounded_d = unbounded;
      count_d     = unbounded ? '0 : load_value;
    end else if (dec && !unbounded_q && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      count_q     <= '0;
      unbounded_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      unbounded_q <= unbounded_d;
    end
  end

  assign count = count_q;
  // An unbounded transfer never runs out of blocks.
  assign zero  = !unbounded_q && (count_q == '0);

endmodule

// File: rtl/xfer_scheduler.sv
// Sequences one SD transaction: command phase, then an optional multi-block data phase.
module xfer_scheduler
  import xfer_scheduler_pkg::*;
#(
  parameter int unsigned CMD_TIMEOUT = 64,
  parameter int unsigned BLK_W       = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             cmd_wr,
  input  logic             data_present,
  input  logic             tm_dma_en,
  input  logic             tm_bcnt_en,
  input  logic             tm_read,
  input  logic             tm_multi,
  input  logic [BLK_W-1:0] blk_count,
  input  logic             gap_stop,
  input  logic             gap_continue,
  input  logic             abort,
  input  logic             cmd_done,
  input  logic             cmd_err,
  input  logic             dat_blk_done,
  input  logic             dat_err,
  output logic             cmd_start,
  output logic             dat_start,
  output logic             dat_dir,
  output logic             dma_start,
  output logic             cmd_inhibit,
  output logic             dat_inhibit,
  output logic [BLK_W-1:0] blk_remaining,
  output logic             int_cmd_cmpl,
  output logic             int_xfer_cmpl,
  output logic             int_gap_evt,
  output logic             err_cmd,
  output logic             err_dat
);

  localparam int unsigned TmoW = $clog2(CMD_TIMEOUT);
  // The timer starts one cycle after cmd_start and err_cmd is registered, hence the offset of 2.
  localparam logic [TmoW-1:0] TmoLast = TmoW'(CMD_TIMEOUT - 2);

  xs_state_e        state_q, state_d;
  logic [TmoW-1:0]  tmo_q, tmo_d;
  xfer_mode_t       mode_q;
  logic             data_present_q;
  logic [BLK_W-1:0] blk_count_q;
  logic             latch;

  logic cmd_start_q, cmd_start_d, dat_start_q, dat_start_d, dma_start_q, dma_start_d;
  logic dat_dir_q, dat_dir_d, cmd_inh_q, cmd_inh_d, dat_inh_q, dat_inh_d;
  logic int_cmd_cmpl_q, int_cmd_cmpl_d, int_xfer_cmpl_q, int_xfer_cmpl_d;
  logic int_gap_evt_q, int_gap_evt_d, err_cmd_q, err_cmd_d, err_dat_q, err_dat_d;

  logic             cnt_load, cnt_dec, unbounded, cnt_zero, last_blk;
  logic [BLK_W-1:0] load_value, count;

  assign unbounded  = mode_q.multi & ~mode_q.bcnt_en;
  assign load_value = mode_q.multi ? blk_count_q : BLK_W'(1);
  assign last_blk   = cnt_zero | (count == BLK_W'(1));

  blk_counter #(
    .BLK_W(BLK_W)
  ) u_blk_counter (
    .CLK       (CLK),
    .RESET     (RESET),
    .load      (cnt_load),
    .load_value(load_value),
    .unbounded (unbounded),
    .dec       (cnt_dec),
    .count     (count),
    .zero      (cnt_zero)
  );

  always_comb begin
    state_d         = state_q;
    tmo_d           = tmo_q;
    latch           = 1'b0;
    cnt_load        = 1'b0;
    cnt_dec         = 1'b0;
    cmd_start_d     = 1'b0;
    dat_start_d     = 1'b0;
    dma_start_d     = 1'b0;
    int_cmd_cmpl_d  = 1'b0;
    int_xfer_cmpl_d = 1'b0;
    int_gap_evt_d   = 1'b0;
    err_cmd_d       = 1'b0;
    err_dat_d       = 1'b0;
    dat_dir_d       = dat_dir_q;
    cmd_inh_d       = cmd_inh_q;
    dat_inh_d       = dat_inh_q;

    if (abort && (state_q != XsIdle)) begin
      state_d   = XsIdle;
      cmd_inh_d = 1'b0;
      dat_inh_d = 1'b0;
    end else begin
      unique case (state_q)
        XsIdle: begin
          if (cmd_wr) begin
            latch       = 1'b1;
            state_d     = XsCmdIssue;
            cmd_start_d = 1'b1;
            cmd_inh_d   = 1'b1;
            dat_inh_d   = data_present;
          end
        end
        XsCmdIssue: begin
          tmo_d   = '0;
          state_d = XsCmdWait;
        end
        XsCmdWait: begin
          if (cmd_err || (tmo_q == TmoLast)) begin
            err_cmd_d = 1'b1;
            cmd_inh_d = 1'b0;
            dat_inh_d = 1'b0;
            state_d   = XsIdle;
          end else if (cmd_done) begin
            int_cmd_cmpl_d = 1'b1;
            cmd_inh_d      = 1'b0;
            if (!data_present_q) begin
              state_d = XsIdle;
            end else begin
              cnt_load  = 1'b1;
              dat_dir_d = mode_q.read;
              if (!unbounded && (load_value == '0)) begin
                state_d = XsDone;
              end else begin
                state_d     = XsDatIssue;
                dat_start_d = 1'b1;
                dma_start_d = mode_q.dma_en;
              end
            end
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
        XsDatIssue: begin
          state_d = XsDatXfer;
        end
        XsDatXfer: begin
          if (dat_err) begin
            err_dat_d = 1'b1;
            dat_inh_d = 1'b0;
            state_d   = XsIdle;
          end else if (dat_blk_done) begin
            cnt_dec = 1'b1;
            if (last_blk) begin
              state_d = XsDone;
            end else if (gap_stop) begin
              state_d       = XsGap;
              int_gap_evt_d = 1'b1;
            end else begin
              state_d     = XsDatIssue;
              dat_start_d = 1'b1;
            end
          end
        end
        XsGap: begin
          if (gap_continue) begin
            state_d     = XsDatIssue;
            dat_start_d = 1'b1;
          end
        end
        XsDone: begin
          int_xfer_cmpl_d = 1'b1;
          dat_inh_d       = 1'b0;
          state_d         = XsIdle;
        end
        default: begin
          state_d = XsIdle;
        end
      endcase
    end

    // Direction only has meaning while a data phase is in flight.
    if (state_d == XsIdle) begin
      dat_dir_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q         <= XsIdle;
      tmo_q           <= '0;
      mode_q          <= '0;
      data_present_q  <= 1'b0;
      blk_count_q     <= '0;
      cmd_start_q     <= 1'b0;
      dat_start_q     <= 1'b0;
      dma_start_q     <= 1'b0;
      dat_dir_q       <= 1'b0;
      cmd_inh_q       <= 1'b0;
      dat_inh_q       <= 1'b0;
      int_cmd_cmpl_q  <= 1'b0;
      int_xfer_cmpl_q <= 1'b0;
      int_gap_evt_q   <= 1'b0;
      err_cmd_q       <= 1'b0;
      err_dat_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      tmo_q           <= tmo_d;
      cmd_start_q     <= cmd_start_d;
      dat_start_q     <= dat_start_d;
      dma_start_q     <= dma_start_d;
      dat_dir_q       <= dat_dir_d;
      cmd_inh_q       <= cmd_inh_d;
      dat_inh_q       <= dat_inh_d;
      int_cmd_cmpl_q  <= int_cmd_cmpl_d;
      int_xfer_cmpl_q <= int_xfer_cmpl_d;
      int_gap_evt_q   <= int_gap_evt_d;
      err_cmd_q       <= err_cmd_d;
      err_dat_q       <= err_dat_d;
      if (latch) begin
        mode_q         <= '{multi: tm_multi, read: tm_read, bcnt_en: tm_bcnt_en,
                            dma_en: tm_dma_en};
        data_present_q <= data_present;
        blk_count_q    <= blk_count;
      end
    end
  end

  assign cmd_start     = cmd_start_q;
  assign dat_start     = dat_start_q;
  assign dma_start     = dma_start_q;
  assign dat_dir       = dat_dir_q;
  assign cmd_inhibit   = cmd_inh_q;
  assign dat_inhibit   = dat_inh_q;
  assign blk_remaining = count;
  assign int_cmd_cmpl  = int_cmd_cmpl_q;
  assign int_xfer_cmpl = int_xfer_cmpl_q;
  assign int_gap_evt   = int_gap_evt_q;
  assign err_cmd       = err_cmd_q;
  assign err_dat       = err_dat_q;

endmodule
